// File: rtl/spi_wb_arbiter_if.sv
// Wishbone bundle for one arbiter port. A requester drives through the master
// modport, and the responding side takes the slave modport.
interface spi_wb_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
) ();
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            stb;
  logic            cyc;
  logic            lock;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;

  modport master (
    output adr, dat_w, sel, we, stb, cyc, lock,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, stb, cyc, lock,
    output dat_r, ack, err
  );
endinterface

// File: rtl/spi_wb_arbiter.sv
// Two-master Wishbone arbiter for the SPI register port. It provides round-robin
// grant, bus lock across access gaps, and an ack timeout that aborts a stuck access.
module spi_wb_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  spi_wb_arbiter_if.slave  m0,
  spi_wb_arbiter_if.slave  m1,
  spi_wb_arbiter_if.master s,
  output logic [1:0]       grant
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [TO_W-1:0] TERM = TO_W'(TIMEOUT - 1);

  state_t          r_state;
  logic [1:0]      r_grant;
  logic            r_last;
  logic [TO_W-1:0] r_count;

  logic [AW-1:0]   w_ownAdr;
  logic [DW-1:0]   w_ownDat;
  logic [DW/8-1:0] w_ownSel;
  logic            w_ownWe;
  logic            w_ownStb;
  logic            w_ownCyc;
  logic            w_ownLock;
  logic            w_abort;
  logic            w_release;

  always_comb begin
    w_ownAdr  = '0;
    w_ownDat  = '0;
    w_ownSel  = '0;
    w_ownWe   = 1'b0;
    w_ownStb  = 1'b0;
    w_ownCyc  = 1'b0;
    w_ownLock = 1'b0;
    if (r_grant[0]) begin
      w_ownAdr  = m0.adr;
      w_ownDat  = m0.dat_w;
      w_ownSel  = m0.sel;
      w_ownWe   = m0.we;
      w_ownStb  = m0.stb;
      w_ownCyc  = m0.cyc;
      w_ownLock = m0.lock;
    end else if (r_grant[1]) begin
      w_ownAdr  = m1.adr;
      w_ownDat  = m1.dat_w;
      w_ownSel  = m1.sel;
      w_ownWe   = m1.we;
      w_ownStb  = m1.stb;
      w_ownCyc  = m1.cyc;
      w_ownLock = m1.lock;
    end
  end

  // An ack or err that lands on the terminal count wins over the abort.
  assign w_abort   = w_ownStb & ~s.ack & ~s.err & (r_count == TERM);
  assign w_release = ~w_ownCyc & ~w_ownLock;

  assign s.adr   = w_ownAdr;
  assign s.dat_w = w_ownDat;
  assign s.sel   = w_ownSel;
  assign s.we    = w_ownWe;
  assign s.stb   = w_ownStb & ~w_abort;
  assign s.cyc   = w_ownCyc & ~w_abort;
  assign s.lock  = w_ownLock;

  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack   = s.ack & r_grant[0];
  assign m1.ack   = s.ack & r_grant[1];
  assign m0.err   = (s.err | w_abort) & r_grant[0];
  assign m1.err   = (s.err | w_abort) & r_grant[1];

  assign grant = r_grant;

  // r_last=1 means m1 held the bus last, so m0 wins the next tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_count <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_count <= '0;
          if (m0.cyc && (!m1.cyc || r_last)) begin
            r_state <= OWN0;
            r_grant <= 2'b01;
          end else if (m1.cyc) begin
            r_state <= OWN1;
            r_grant <= 2'b10;
          end
        end
        OWN0, OWN1: begin
          if (w_release) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_last  <= (r_state == OWN1);
            r_count <= '0;
          end else if (w_ownStb && !s.ack && !s.err && !w_abort) begin
            r_count <= r_count + 1'b1;
          end else begin
            r_count <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 2'b00;
          r_count <= '0;
        end
      endcase
    end
  end

endmodule
